// File: rtl/toggle_event_decoder_pkg.sv
//==============================================================================
// Module   : toggle_event_decoder_pkg
// Purpose  : Shared defaults and pending-counter update decode for the
//            toggle-line event decoder (also used by the TFF transmitter).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package toggle_event_decoder_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 4;
    localparam int TOT_W_DEF       = 16;

    typedef enum logic [1:0] {
        PEND_HOLD = 2'd0,
        PEND_INC  = 2'd1,
        PEND_DEC  = 2'd2,
        PEND_SAT  = 2'd3
    } pend_op_e;

    // Simultaneous arrival and consumption cancel out, so a full counter
    // never overflows while the consumer is draining it.
    function automatic pend_op_e pend_op(input logic inc, input logic dec,
                                         input logic at_max);
        if (inc && !dec) begin
            return at_max ? PEND_SAT : PEND_INC;
        end
        if (!inc && dec) begin
            return PEND_DEC;
        end
        return PEND_HOLD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/toggle_edge_sync.sv
//==============================================================================
// Module   : toggle_edge_sync
// Purpose  : Synchronizes the toggle line and flags every level transition.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module toggle_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk1,
    input  logic s_reset,
    input  logic tog_in,
    output logic edge_out
);

    logic w_level;
    logic r_prev;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            // Same-clock sender: the line is already synchronous.
            assign w_level = tog_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_chain;

            always_ff @(posedge clk1) begin
                if (s_reset) begin
                    r_chain <= '0;
                end else begin
                    r_chain[0] <= tog_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_chain[i] <= r_chain[i-1];
                    end
                end
            end

            assign w_level = r_chain[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk1) begin
        if (s_reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign edge_out = w_level ^ r_prev;

endmodule

`default_nettype wire

// File: rtl/toggle_event_decoder.sv
//==============================================================================
// Module   : toggle_event_decoder
// Purpose  : Recovers events from a toggle line, buffers them in a saturating
//            counter and offers them to a consumer over valid/ready.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module toggle_event_decoder
    import toggle_event_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TOT_W       = TOT_W_DEF
) (
    input  logic             clk1,
    input  logic             s_reset,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic [TOT_W-1:0] total_count
);

    localparam logic [CNT_W-1:0] c_pend_max = '1;

    logic             w_edge;
    logic             w_dec;
    pend_op_e         w_op;

    logic             r_pulse;
    logic [CNT_W-1:0] r_pend;
    logic             r_ovf;
    logic [TOT_W-1:0] r_total;

    toggle_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk1     (clk1),
        .s_reset  (s_reset),
        .tog_in   (tog_in),
        .edge_out (w_edge)
    );

    // evt_valid already gates the handshake, so ready on an empty counter
    // can never underflow it.
    assign w_dec = evt_valid && evt_ready;
    assign w_op  = pend_op(w_edge, w_dec, (r_pend == c_pend_max));

    always_ff @(posedge clk1) begin
        if (s_reset) begin
            r_pulse <= 1'b0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_total <= '0;
        end else begin
            r_pulse <= w_edge;
            r_total <= r_total + TOT_W'(w_edge);

            case (w_op)
                PEND_INC: r_pend <= r_pend + CNT_W'(1);
                PEND_DEC: r_pend <= r_pend - CNT_W'(1);
                default:  r_pend <= r_pend;
            endcase

            // A drop in the same cycle as a clear must stay visible.
            if (w_op == PEND_SAT) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign evt_pulse   = r_pulse;
    assign evt_valid   = (r_pend != '0);
    assign pending     = r_pend;
    assign overflow    = r_ovf;
    assign total_count = r_total;

endmodule

`default_nettype wire

// File: tb/tb_toggle_event_decoder.sv
//==============================================================================
// Module   : tb_toggle_event_decoder
// Purpose  : Self-checking bench for toggle_event_decoder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_toggle_event_decoder;

    localparam int SYNC = 2;
    localparam int CW   = 4;
    localparam int TW   = 16;
    localparam int MAXP = (1 << CW) - 1;

    logic          clk1 = 1'b0;
    logic          s_reset = 1'b1;
    logic          tog_in = 1'b0;
    logic          evt_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          evt_pulse;
    logic          evt_valid;
    logic [CW-1:0] pending;
    logic          overflow;
    logic [TW-1:0] total_count;

    int total = 0;
    int bad   = 0;

    // Reference model: a delay line of sampled line levels plus plain counters.
    int   m_line[$];
    int   m_pend;
    int   m_tot;
    logic m_ovf;
    logic m_pulse;
    logic lvl;

    toggle_event_decoder #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (CW),
        .TOT_W       (TW)
    ) dut (
        .clk1        (clk1),
        .s_reset     (s_reset),
        .tog_in      (tog_in),
        .evt_ready   (evt_ready),
        .clr_ovf     (clr_ovf),
        .evt_pulse   (evt_pulse),
        .evt_valid   (evt_valid),
        .pending     (pending),
        .overflow    (overflow),
        .total_count (total_count)
    );

    always #5 clk1 = ~clk1;

    task automatic model_step(input logic t, input logic r, input logic c,
                              input logic rs);
        logic ev;
        logic dec;
        logic sat;
        if (rs) begin
            m_line.delete();
            for (int i = 0; i <= SYNC; i++) m_line.push_back(0);
            m_pend  = 0;
            m_tot   = 0;
            m_ovf   = 1'b0;
            m_pulse = 1'b0;
        end else begin
            m_line.push_back(int'(t));
            ev  = (m_line[0] != m_line[1]);
            void'(m_line.pop_front());
            dec = (m_pend > 0) && r;
            sat = ev && !dec && (m_pend == MAXP);
            if (ev && !dec && m_pend < MAXP) m_pend = m_pend + 1;
            else if (!ev && dec)             m_pend = m_pend - 1;
            if (sat)      m_ovf = 1'b1;
            else if (c)   m_ovf = 1'b0;
            m_tot   = (m_tot + int'(ev)) % (1 << TW);
            m_pulse = ev;
        end
    endtask

    task automatic cycle(input logic t, input logic r, input logic c,
                         input logic rs);
        tog_in    = t;
        evt_ready = r;
        clr_ovf   = c;
        s_reset   = rs;
        lvl       = t;
        @(posedge clk1);
        model_step(t, r, c, rs);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (evt_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b want=0", evt_pulse); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", evt_valid); end
        total++; if (pending !== '0) begin bad++; $display("FAIL reset_pending got=%0d want=0", pending); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (total_count !== '0) begin bad++; $display("FAIL reset_total got=%0d want=0", total_count); end
    endtask

    task automatic test_latency();
        logic [3:0] seen;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            seen[i] = evt_pulse;
        end
        total++; if (seen !== 4'b0100) begin bad++; $display("FAIL latency_pulse_seq got=%b want=0100", seen); end
        total++; if (pending !== 4'd1 || evt_valid !== 1'b1) begin bad++; $display("FAIL latency_pending got=%0d/%b want=1/1", pending, evt_valid); end
        total++; if (total_count !== 16'd1) begin bad++; $display("FAIL latency_total got=%0d want=1", total_count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen;
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle((i < 6) ? ~lvl : lvl, 1'b0, 1'b0, 1'b0);
            seen[i] = evt_pulse;
        end
        total++; if (seen !== 8'b1111_1100) begin bad++; $display("FAIL b2b_pulse_seq got=%b want=11111100", seen); end
        total++; if (pending !== 4'd6) begin bad++; $display("FAIL b2b_pending got=%0d want=6", pending); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 17; i++) cycle(~lvl, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SYNC; i++) cycle(lvl, 1'b0, 1'b0, 1'b0);
        total++; if (pending !== 4'd15) begin bad++; $display("FAIL sat_pending got=%0d want=15", pending); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_overflow got=%b want=1", overflow); end
        total++; if (total_count !== 16'd17) begin bad++; $display("FAIL sat_total got=%0d want=17", total_count); end
        cycle(lvl, 1'b0, 1'b1, 1'b0);
        total++; if (overflow !== 1'b0 || pending !== 4'd15) begin bad++; $display("FAIL sat_clr got=%b/%0d want=0/15", overflow, pending); end
        // Event arrives SYNC edges after the toggle, exactly when ready is high.
        cycle(~lvl, 1'b0, 1'b0, 1'b0);
        cycle(lvl, 1'b0, 1'b0, 1'b0);
        cycle(lvl, 1'b1, 1'b0, 1'b0);
        total++; if (evt_pulse !== 1'b1) begin bad++; $display("FAIL sat_inc_dec_pulse got=%b want=1", evt_pulse); end
        total++; if (pending !== 4'd15 || overflow !== 1'b0) begin bad++; $display("FAIL sat_inc_dec got=%0d/%b want=15/0", pending, overflow); end
        total++; if (total_count !== 16'd18) begin bad++; $display("FAIL sat_inc_dec_total got=%0d want=18", total_count); end
    endtask

    task automatic test_drain();
        int exp_d[5] = '{2, 1, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 3; i++) cycle(~lvl, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SYNC; i++) cycle(lvl, 1'b0, 1'b0, 1'b0);
        total++; if (pending !== 4'd3) begin bad++; $display("FAIL drain_start got=%0d want=3", pending); end
        for (int i = 0; i < 5; i++) begin
            cycle(lvl, 1'b1, 1'b0, 1'b0);
            total++;
            if (pending !== exp_d[i][CW-1:0] || evt_valid !== (exp_d[i] != 0)) begin
                bad++;
                $display("FAIL drain_step%0d got=%0d/%b want=%0d/%b", i, pending, evt_valid, exp_d[i], exp_d[i] != 0);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 17; i++) cycle(~lvl, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SYNC; i++) cycle(lvl, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(lvl, 1'b1, 1'b0, 1'b0);
        total++; if (pending !== 4'd5 || overflow !== 1'b1 || lvl !== 1'b1) begin bad++; $display("FAIL rmid_setup got=%0d/%b want=5/1", pending, overflow); end
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (evt_pulse !== 1'b0 || evt_valid !== 1'b0 || pending !== '0 || overflow !== 1'b0 || total_count !== '0) begin
            bad++;
            $display("FAIL rmid_cleared got=p%b v%b n%0d o%b t%0d want=all 0", evt_pulse, evt_valid, pending, overflow, total_count);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (pending !== 4'd1 || total_count !== 16'd1) begin bad++; $display("FAIL rmid_after got=%0d/%0d want=1/1", pending, total_count); end
    endtask

    task automatic test_random();
        logic t;
        logic r;
        logic c;
        logic rs;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            t  = ($urandom_range(0, 2) != 0) ? ~lvl : lvl;
            r  = (n < 400) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
            c  = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 199) == 0);
            cycle(t, r, c, rs);
            total++; if (evt_pulse !== m_pulse) begin bad++; $display("FAIL rand_pulse n=%0d got=%b want=%b", n, evt_pulse, m_pulse); end
            total++; if (pending !== m_pend[CW-1:0]) begin bad++; $display("FAIL rand_pending n=%0d got=%0d want=%0d", n, pending, m_pend); end
            total++; if (evt_valid !== (m_pend != 0)) begin bad++; $display("FAIL rand_valid n=%0d got=%b want=%b", n, evt_valid, m_pend != 0); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rand_overflow n=%0d got=%b want=%b", n, overflow, m_ovf); end
            total++; if (total_count !== m_tot[TW-1:0]) begin bad++; $display("FAIL rand_total n=%0d got=%0d want=%0d", n, total_count, m_tot); end
        end
    endtask

    initial begin
        lvl = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_saturation();
        test_drain();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
